// File: rtl/shift_seq_pkg.sv
// Shared constants and FSM state encoding for the shift sequencer.
package shift_seq_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/shift_expect.sv
// Combinational reference shift: arithmetic or logical right shift of a value by an amount.
module shift_expect #(
    parameter int WIDTH = shift_seq_pkg::WIDTH,
    parameter int CNT_W = shift_seq_pkg::CNT_W
) (
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] amount,
    input  logic             arith,
    output logic [WIDTH-1:0] expected
);
    import shift_seq_pkg::*;

    logic signed [WIDTH-1:0] data_s;
    logic signed [WIDTH-1:0] asr_val;
    logic        [WIDTH-1:0] lsr_val;

    // Kept as separate signed/unsigned nets so >>> is not evaluated in an unsigned context.
    assign data_s   = data;
    assign asr_val  = data_s >>> amount;
    assign lsr_val  = data >> amount;
    assign expected = arith ? asr_val : lsr_val;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for an external load/shift-right/ASR register: load, N shifts,
// capture, and return the result with a self-check flag.
module shift_sequencer #(
    parameter int WIDTH = shift_seq_pkg::WIDTH,
    parameter int CNT_W = shift_seq_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_amount,
    input  logic             cmd_arith,
    output logic [WIDTH-1:0] sh_load_val,
    output logic             sh_load_n,
    output logic             sh_shift,
    output logic             sh_asr,
    input  logic [WIDTH-1:0] sh_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_mismatch
);
    import shift_seq_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] amt_q;
    logic             arith_q;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_mis_q;

    shift_expect #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_expect (
        .data     (data_q),
        .amount   (amt_q),
        .arith    (arith_q),
        .expected (expected)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        sh_load_n = 1'b1;
        sh_shift  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sh_load_n = 1'b0;
                state_nxt = (cnt != '0) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
                sh_shift = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Fill select follows the latched command for the whole operation, dropped only in IDLE.
    assign sh_asr       = (state != IDLE) && arith_q;
    assign sh_load_val  = data_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_mismatch = rsp_mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            data_q     <= '0;
            amt_q      <= '0;
            arith_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_mis_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        data_q  <= cmd_data;
                        amt_q   <= cmd_amount;
                        arith_q <= cmd_arith;
                        cnt     <= cmd_amount;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                CAPTURE: begin
                    rsp_data_q <= sh_q;
                    rsp_mis_q  <= (sh_q != expected);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural shift register plus arithmetic reference model.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amount;
    logic       cmd_arith;
    logic [7:0] sh_load_val;
    logic       sh_load_n;
    logic       sh_shift;
    logic       sh_asr;
    logic [7:0] sh_q;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_mismatch;

    logic [7:0] sq;
    logic       flip = 1'b0;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_amount   (cmd_amount),
        .cmd_arith    (cmd_arith),
        .sh_load_val  (sh_load_val),
        .sh_load_n    (sh_load_n),
        .sh_shift     (sh_shift),
        .sh_asr       (sh_asr),
        .sh_q         (sh_q),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_mismatch (rsp_mismatch)
    );

    // Downstream register: load / shift right with optional sign fill / hold.
    always @(posedge clk) begin
        if (!sh_load_n) sq <= sh_load_val;
        else if (sh_shift) sq <= {(sh_asr ? sq[7] : 1'b0), sq[7:1]};
    end
    assign sh_q = sq ^ {7'b0, flip};

    // Shift as integer division: floor for negative signed values, truncation otherwise.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input bit ar);
        int s;
        int p;
        p = 1 << a;
        if (ar && d[7]) begin
            s = int'(d) - 256;
            s = (s - (p - 1)) / p;
        end else begin
            s = int'(d) / p;
        end
        return s[7:0];
    endfunction

    // Caller is at a negedge with the DUT idle; returns at the negedge where rsp_valid is seen.
    task automatic run_cmd(input logic [7:0] d, input logic [2:0] a, input logic ar,
                           input bit inject, output int loads, output int shifts,
                           output int lat, output int asr_bad, output int both);
        cmd_data   = d;
        cmd_amount = a;
        cmd_arith  = ar;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        loads = 0; shifts = 0; lat = -1; asr_bad = 0; both = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!sh_load_n) loads++;
            if (sh_shift) shifts++;
            if (!sh_load_n && sh_shift) both++;
            if (sh_asr !== ar) asr_bad++;
            flip = inject && (k == int'(a) + 2);
            if (rsp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        flip = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_data = '0; cmd_amount = '0; cmd_arith = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
        checks++; if (sh_load_n !== 1'b1) $display("FAIL reset_load_n got %b want 1", sh_load_n); else passes++;
        checks++; if (sh_shift !== 1'b0) $display("FAIL reset_shift got %b want 0", sh_shift); else passes++;
        checks++; if (sh_asr !== 1'b0) $display("FAIL reset_asr got %b want 0", sh_asr); else passes++;
        checks++; if (sh_load_val !== 8'h00) $display("FAIL reset_load_val got %h want 00", sh_load_val); else passes++;
        checks++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data got %h want 00", rsp_data); else passes++;
        checks++; if (rsp_mismatch !== 1'b0) $display("FAIL reset_mismatch got %b want 0", rsp_mismatch); else passes++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed(input string name, input logic [7:0] d, input logic [2:0] a,
                                 input logic ar, input bit inject, input logic [7:0] want,
                                 input logic want_mis);
        int loads, shifts, lat, asr_bad, both;
        run_cmd(d, a, ar, inject, loads, shifts, lat, asr_bad, both);
        checks++; if (loads !== 1) $display("FAIL %s_loads got %0d want 1", name, loads); else passes++;
        checks++; if (shifts !== int'(a)) $display("FAIL %s_shifts got %0d want %0d", name, shifts, a); else passes++;
        checks++; if (lat !== int'(a) + 3) $display("FAIL %s_latency got %0d want %0d", name, lat, int'(a) + 3); else passes++;
        checks++; if (both !== 0) $display("FAIL %s_overlap got %0d want 0", name, both); else passes++;
        checks++; if (asr_bad !== 0) $display("FAIL %s_asr got %0d bad cycles want 0", name, asr_bad); else passes++;
        checks++; if (rsp_data !== want) $display("FAIL %s_data got %h want %h", name, rsp_data, want); else passes++;
        checks++; if (rsp_mismatch !== want_mis) $display("FAIL %s_mismatch got %b want %b", name, rsp_mismatch, want_mis); else passes++;
        finish_rsp();
    endtask

    task automatic test_random();
        int loads, shifts, lat, asr_bad, both;
        logic [7:0] d;
        logic [2:0] a;
        logic       ar;
        logic [7:0] want;
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            a  = 3'($urandom_range(7));
            ar = 1'($urandom);
            want = ref_shift(d, int'(a), ar);
            run_cmd(d, a, ar, 1'b0, loads, shifts, lat, asr_bad, both);
            checks++;
            if (rsp_data !== want || rsp_mismatch !== 1'b0 || lat !== int'(a) + 3 || shifts !== int'(a)
                || loads !== 1 || asr_bad !== 0 || both !== 0)
                $display("FAIL rand_%0d d=%h a=%0d ar=%b got data=%h mis=%b lat=%0d sh=%0d want data=%h mis=0 lat=%0d sh=%0d",
                         i, d, a, ar, rsp_data, rsp_mismatch, lat, shifts, want, int'(a) + 3, a);
            else passes++;
            finish_rsp();
        end
    endtask

    task automatic test_back_to_back();
        int loads, shifts, lat, asr_bad, both;
        int bad;
        logic [7:0] want2;
        run_cmd(8'h3C, 3'd2, 1'b0, 1'b0, loads, shifts, lat, asr_bad, both);
        cmd_data = 8'hA5; cmd_amount = 3'd4; cmd_arith = 1'b1; cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h0F || rsp_mismatch !== 1'b0 || cmd_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad); else passes++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL bp_idle got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); else passes++;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (sh_load_n !== 1'b0 || sh_load_val !== 8'hA5) $display("FAIL bp_second_accept got load_n=%b val=%h want 0/a5", sh_load_n, sh_load_val); else passes++;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        want2 = ref_shift(8'hA5, 4, 1'b1);
        checks++; if (lat < 0 || rsp_data !== want2 || rsp_mismatch !== 1'b0) $display("FAIL bp_second_result got %h mis=%b lat=%0d want %h mis=0", rsp_data, rsp_mismatch, lat, want2); else passes++;
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        bit seen;
        cmd_data = 8'hFF; cmd_amount = 3'd7; cmd_arith = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sh_shift !== 1'b1) $display("FAIL rstmid_in_shift got %b want 1", sh_shift); else passes++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (sh_shift !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rstmid_idle got shift=%b ready=%b valid=%b want 0/1/0", sh_shift, cmd_ready, rsp_valid); else passes++;
        checks++; if (sh_load_val !== 8'h00 || sh_asr !== 1'b0 || rsp_data !== 8'h00) $display("FAIL rstmid_clear got val=%h asr=%b data=%h want 00/0/00", sh_load_val, sh_asr, rsp_data); else passes++;
        seen = 1'b0;
        repeat (15) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) $display("FAIL rstmid_no_rsp got %b want 0", seen); else passes++;
    endtask

    initial begin
        test_reset();
        test_directed("logical", 8'hB4, 3'd3, 1'b0, 1'b0, 8'h16, 1'b0);
        test_directed("arith", 8'hB4, 3'd3, 1'b1, 1'b0, 8'hF6, 1'b0);
        test_directed("zero", 8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0);
        test_directed("max", 8'h81, 3'd7, 1'b1, 1'b0, 8'hFF, 1'b0);
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_directed("fault", 8'h80, 3'd1, 1'b1, 1'b1, 8'hC1, 1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
